// File: rtl/mbisr_ctrl_pkg.sv
// Shared types for the MBISR repair-chain controller: command ops, FSM states
// and the default data word width.
package mbisr_ctrl_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        OP_LOAD          = 2'd0,
        OP_UNLOAD        = 2'd1,
        OP_UNLOAD_RECIRC = 2'd2
    } mbisr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_FLUSH   = 2'd3
    } mbisr_state_e;

    // The reserved encoding behaves as a plain unload.
    function automatic mbisr_op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd0:    return OP_LOAD;
            2'd2:    return OP_UNLOAD_RECIRC;
            default: return OP_UNLOAD;
        endcase
    endfunction

endpackage

// File: rtl/mbisr_chain_ctrl_if.sv
// Command, load-word and unload-word handshakes between the repair-data
// engine (master) and the chain controller (slave).
interface mbisr_chain_ctrl_if #(
    parameter int W = mbisr_ctrl_pkg::DEF_W
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;

    modport master (
        output cmd_valid, cmd_op, wr_data, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, wr_data, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/mbisr_ctrl_wordbuf.sv
// W-bit serializer/deserializer: loaded words shift out from bit 0, unload
// bits are assembled at the running bit index and cleared per word.
module mbisr_ctrl_wordbuf #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         bit_in,
    input  logic         last,
    output logic         bit_out,
    output logic         full,
    output logic         at_last,
    output logic [W-1:0] word
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  data;
    logic [IW-1:0] idx;

    assign at_last = (idx == IW'(W - 1));
    assign bit_out = data[idx];
    assign word    = data | (W'(bit_in) << idx);

    // A load on the cycle the final bit leaves takes priority over emptying.
    always_ff @(posedge CLK) begin
        if (!RSTB || clr) begin
            data <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            idx  <= '0;
            full <= 1'b1;
        end else if (shift) begin
            if (at_last || last) begin
                data <= '0;
                idx  <= '0;
                full <= 1'b0;
            end else begin
                data[idx] <= bit_in;
                idx       <= idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/mbisr_chain_ctrl.sv
// MBISR repair-chain controller: loads words onto the scan chain or captures
// and unloads it (optionally recirculating), with stall-by-clock-enable.
module mbisr_chain_ctrl
    import mbisr_ctrl_pkg::*;
#(
    parameter int LEN = 26,
    parameter int W   = DEF_W
) (
    input  logic              CLK,
    input  logic              RSTB,
    mbisr_chain_ctrl_if.slave bus,
    output logic              chain_se,
    output logic              chain_si,
    output logic              chain_ce,
    input  logic              chain_so,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    mbisr_state_e  state;
    mbisr_op_e     op;
    mbisr_op_e     op_in;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rd_word;
    logic          rd_vld;
    logic          cmd_take, is_load, last_bit, word_end, shift, wr_fire;
    logic          buf_bit, buf_full, buf_at_last;
    logic [W-1:0]  buf_word;

    assign op_in    = decode_op(bus.cmd_op);
    assign cmd_take = (state == ST_IDLE) && bus.cmd_valid;
    assign is_load  = (op == OP_LOAD);
    assign last_bit = (cnt == LAST);
    assign word_end = buf_at_last || last_bit;

    // Chain pins depend only on registered state, so no handshake input can
    // glitch the ICG enable.
    always_comb begin
        chain_se = 1'b0;
        chain_ce = 1'b0;
        chain_si = 1'b0;
        case (state)
            ST_CAPTURE: chain_ce = 1'b1;
            ST_SHIFT: begin
                chain_se = 1'b1;
                if (is_load) begin
                    chain_ce = buf_full;
                    chain_si = buf_bit;
                end else begin
                    chain_ce = !(rd_vld && word_end);
                    chain_si = (op == OP_UNLOAD_RECIRC) && chain_so;
                end
            end
            default: ;
        endcase
    end

    assign shift        = (state == ST_SHIFT) && chain_ce;
    assign bus.wr_ready = (state == ST_SHIFT) && is_load &&
                          (!buf_full || (buf_at_last && !last_bit));
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign bus.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign bus.rd_data   = rd_word;
    assign bus.rd_valid  = rd_vld;

    mbisr_ctrl_wordbuf #(.W(W)) u_buf (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .clr       (cmd_take),
        .load      (wr_fire),
        .load_data (bus.wr_data),
        .shift     (shift),
        .bit_in    (chain_so),
        .last      (last_bit),
        .bit_out   (buf_bit),
        .full      (buf_full),
        .at_last   (buf_at_last),
        .word      (buf_word)
    );

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state   <= ST_IDLE;
            op      <= OP_LOAD;
            cnt     <= '0;
            rd_word <= '0;
            rd_vld  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rd_vld && bus.rd_ready) rd_vld <= 1'b0;
            case (state)
                ST_IDLE: if (bus.cmd_valid) begin
                    op    <= op_in;
                    cnt   <= '0;
                    state <= (op_in == OP_LOAD) ? ST_SHIFT : ST_CAPTURE;
                end
                ST_CAPTURE: state <= ST_SHIFT;
                ST_SHIFT: if (shift) begin
                    cnt <= cnt + CW'(1);
                    if (!is_load && word_end) begin
                        rd_word <= buf_word;
                        rd_vld  <= 1'b1;
                    end
                    if (last_bit) begin
                        if (is_load) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: if (!rd_vld || bus.rd_ready) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbisr_chain_ctrl.sv
// Directed bench: two controllers (LEN=26, LEN=70) each driving a behavioural
// MBISR chain model; hand-computed expectations for load/unload/stall/reset.
module tb_mbisr_chain_ctrl;
    import mbisr_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    mbisr_chain_ctrl_if #(.W(32)) b26 ();
    mbisr_chain_ctrl_if #(.W(32)) b70 ();

    logic se26, si26, ce26, so26, busy26, done26;
    logic se70, si70, ce70, so70, busy70, done70;

    mbisr_chain_ctrl #(.LEN(26), .W(32)) dut26 (
        .CLK(CLK), .RSTB(RSTB), .bus(b26),
        .chain_se(se26), .chain_si(si26), .chain_ce(ce26), .chain_so(so26),
        .busy(busy26), .done(done26)
    );

    mbisr_chain_ctrl #(.LEN(70), .W(32)) dut70 (
        .CLK(CLK), .RSTB(RSTB), .bus(b70),
        .chain_se(se70), .chain_si(si70), .chain_ce(ce70), .chain_so(so70),
        .busy(busy70), .done(done70)
    );

    // Chain models: capture D (or hold Q) on SE=0, shift toward SO on SE=1,
    // SO retimed on the falling edge.
    logic [25:0] q26, dd26 = '0, pv26 = '0;
    logic [69:0] q70, dd70 = '0, pv70 = '0;
    logic pre26 = 1'b0, hold26 = 1'b0, pre70 = 1'b0, hold70 = 1'b0;

    always @(posedge CLK) begin
        if (pre26)     q26 <= pv26;
        else if (ce26) q26 <= se26 ? {si26, q26[25:1]} : (hold26 ? q26 : dd26);
    end
    always @(negedge CLK) so26 <= q26[0];

    always @(posedge CLK) begin
        if (pre70)     q70 <= pv70;
        else if (ce70) q70 <= se70 ? {si70, q70[69:1]} : (hold70 ? q70 : dd70);
    end
    always @(negedge CLK) so70 <= q70[0];

    // Event counters; tests work with deltas so nothing else writes these.
    int sh26 = 0, cap26 = 0, wa26 = 0, rc26 = 0;
    int sh70 = 0, cap70 = 0, wa70 = 0, rc70 = 0;
    logic [31:0] rw26 [64];
    logic [31:0] rw70 [64];

    always @(posedge CLK) begin
        if (ce26 && se26)  sh26 <= sh26 + 1;
        if (ce26 && !se26) cap26 <= cap26 + 1;
        if (b26.wr_valid && b26.wr_ready) wa26 <= wa26 + 1;
        if (b26.rd_valid && b26.rd_ready) begin
            rw26[rc26 % 64] <= b26.rd_data;
            rc26 <= rc26 + 1;
        end
        if (ce70 && se70)  sh70 <= sh70 + 1;
        if (ce70 && !se70) cap70 <= cap70 + 1;
        if (b70.wr_valid && b70.wr_ready) wa70 <= wa70 + 1;
        if (b70.rd_valid && b70.rd_ready) begin
            rw70[rc70 % 64] <= b70.rd_data;
            rc70 <= rc70 + 1;
        end
    end

    task automatic preset26(input logic [25:0] v);
        @(negedge CLK); pv26 = v; pre26 = 1'b1;
        @(negedge CLK); pre26 = 1'b0;
    endtask

    task automatic preset70(input logic [69:0] v);
        @(negedge CLK); pv70 = v; pre70 = 1'b1;
        @(negedge CLK); pre70 = 1'b0;
    endtask

    // Returns at the falling edge of the cycle after the accept edge.
    task automatic issue26(input logic [1:0] op);
        @(negedge CLK); b26.cmd_op = op; b26.cmd_valid = 1'b1;
        @(negedge CLK); b26.cmd_valid = 1'b0;
    endtask

    task automatic issue70(input logic [1:0] op);
        @(negedge CLK); b70.cmd_op = op; b70.cmd_valid = 1'b1;
        @(negedge CLK); b70.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({se26, ce26, si26, busy26, done26, b26.wr_ready, b26.rd_valid} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset26_outputs: got %b want 0000000",
                     {se26, ce26, si26, busy26, done26, b26.wr_ready, b26.rd_valid});
        end
        n_cmp++;
        if ({se70, ce70, si70, busy70, done70, b70.wr_ready, b70.rd_valid} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset70_outputs: got %b want 0000000",
                     {se70, ce70, si70, busy70, done70, b70.wr_ready, b70.rd_valid});
        end
        RSTB = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (b26.cmd_ready !== 1'b1 || b70.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cmd_ready: got %b%b want 11", b26.cmd_ready, b70.cmd_ready);
        end
    endtask

    task automatic test_load26();
        int k, s0, w0;
        preset26(26'h0);
        b26.wr_data = 32'h02A5_5A5A;
        b26.wr_valid = 1'b1;
        s0 = sh26; w0 = wa26;
        issue26(2'd0);
        n_cmp++;
        if (busy26 !== 1'b1 || b26.wr_ready !== 1'b1 || ce26 !== 1'b0) begin
            n_bad++;
            $display("FAIL load26_start: busy/wr_ready/ce got %b%b%b want 110",
                     busy26, b26.wr_ready, ce26);
        end
        k = 1;
        while (!done26 && k < 200) begin @(negedge CLK); k++; end
        b26.wr_valid = 1'b0;
        n_cmp++;
        if (k != 28) begin n_bad++; $display("FAIL load26_done_cycle: got %0d want 28", k); end
        n_cmp++;
        if (q26 !== 26'h2A5_5A5A) begin
            n_bad++; $display("FAIL load26_chain: got %h want %h", q26, 26'h2A5_5A5A);
        end
        n_cmp++;
        if (sh26 - s0 != 26) begin n_bad++; $display("FAIL load26_shifts: got %0d want 26", sh26 - s0); end
        n_cmp++;
        if (wa26 - w0 != 1) begin n_bad++; $display("FAIL load26_words: got %0d want 1", wa26 - w0); end
        n_cmp++;
        if (b26.cmd_ready !== 1'b1 || busy26 !== 1'b0) begin
            n_bad++; $display("FAIL load26_idle: cmd_ready/busy got %b%b want 10", b26.cmd_ready, busy26);
        end
    endtask

    task automatic test_unload26();
        int k, s0, c0, r0, first;
        preset26(26'h3FF_FFFF);
        dd26 = 26'h155_AAAA; hold26 = 1'b0; b26.rd_ready = 1'b1;
        s0 = sh26; c0 = cap26; r0 = rc26; first = 0;
        issue26(2'd1);
        n_cmp++;
        if (se26 !== 1'b0 || ce26 !== 1'b1) begin
            n_bad++; $display("FAIL unload26_capture: se/ce got %b%b want 01", se26, ce26);
        end
        k = 1;
        while (!done26 && k < 200) begin
            if (b26.rd_valid && first == 0) first = k;
            @(negedge CLK); k++;
        end
        n_cmp++;
        if (first != 28 || k != 29) begin
            n_bad++; $display("FAIL unload26_timing: rd_valid@%0d done@%0d want 28 29", first, k);
        end
        n_cmp++;
        if (rc26 - r0 != 1 || rw26[r0 % 64] !== 32'h0155_AAAA) begin
            n_bad++; $display("FAIL unload26_word: got %0d words first %h want 1 words 0155aaaa",
                              rc26 - r0, rw26[r0 % 64]);
        end
        n_cmp++;
        if (cap26 - c0 != 1 || sh26 - s0 != 26) begin
            n_bad++; $display("FAIL unload26_cycles: capture %0d shifts %0d want 1 26", cap26 - c0, sh26 - s0);
        end
        n_cmp++;
        if (q26 !== 26'h0) begin n_bad++; $display("FAIL unload26_chain: got %h want 0", q26); end
    endtask

    task automatic test_recirc70();
        int k, r0;
        logic [69:0] pat;
        pat = 70'h2B_CAFE_F00D_1357_9BDF;
        preset70(pat);
        hold70 = 1'b1; b70.rd_ready = 1'b1; r0 = rc70;
        issue70(2'd2);
        k = 1;
        while (!done70 && k < 300) begin @(negedge CLK); k++; end
        n_cmp++;
        if (k != 73) begin n_bad++; $display("FAIL recirc70_done_cycle: got %0d want 73", k); end
        n_cmp++;
        if (rc70 - r0 != 3 || rw70[r0 % 64] !== 32'h1357_9BDF || rw70[(r0 + 1) % 64] !== 32'hCAFE_F00D
            || rw70[(r0 + 2) % 64] !== 32'h0000_002B) begin
            n_bad++; $display("FAIL recirc70_words: n=%0d %h %h %h want 3 13579bdf cafef00d 0000002b",
                              rc70 - r0, rw70[r0 % 64], rw70[(r0 + 1) % 64], rw70[(r0 + 2) % 64]);
        end
        n_cmp++;
        if (q70 !== pat) begin n_bad++; $display("FAIL recirc70_chain: got %h want %h", q70, pat); end
        hold70 = 1'b0;
    endtask

    task automatic test_load_stall70();
        int k, s0, w0, wi, stalls, bad_se;
        logic [31:0] lw [3];
        lw[0] = 32'h89AB_CDEF; lw[1] = 32'h0123_4567; lw[2] = 32'h0000_0015;
        preset70(70'h0);
        s0 = sh70; w0 = wa70; wi = 0; stalls = 0; bad_se = 0;
        b70.wr_data = lw[0]; b70.wr_valid = 1'b1;
        issue70(2'd0);
        k = 1;
        while (!done70 && k < 400) begin
            if (wi == 1 && !ce70) begin
                stalls++;
                if (se70 !== 1'b1) bad_se++;
            end
            b70.wr_data  = (wi < 3) ? lw[wi] : 32'h0;
            b70.wr_valid = (wi != 1) || (stalls >= 5);
            #1;
            if (b70.wr_valid && b70.wr_ready) wi++;
            @(negedge CLK); k++;
        end
        b70.wr_valid = 1'b0;
        n_cmp++;
        if (stalls != 5 || bad_se != 0) begin
            n_bad++; $display("FAIL stall70_load_gap: stalls %0d se_low %0d want 5 0", stalls, bad_se);
        end
        n_cmp++;
        if (k != 77) begin n_bad++; $display("FAIL stall70_load_done: got %0d want 77", k); end
        n_cmp++;
        if (sh70 - s0 != 70 || wa70 - w0 != 3) begin
            n_bad++; $display("FAIL stall70_load_counts: shifts %0d words %0d want 70 3", sh70 - s0, wa70 - w0);
        end
        n_cmp++;
        if (q70 !== 70'h15_0123_4567_89AB_CDEF) begin
            n_bad++; $display("FAIL stall70_load_chain: got %h want 150123456789abcdef", q70);
        end
    endtask

    task automatic test_unload_stall70();
        int k, s0, r0, s1;
        dd70 = 70'h15_0123_4567_89AB_CDEF; hold70 = 1'b0; b70.rd_ready = 1'b0;
        s0 = sh70; r0 = rc70;
        issue70(2'd1);
        k = 1;
        while (!(se70 && !ce70) && k < 200) begin @(negedge CLK); k++; end
        n_cmp++;
        if (sh70 - s0 != 63 || b70.rd_valid !== 1'b1 || b70.rd_data !== 32'h89AB_CDEF) begin
            n_bad++; $display("FAIL stall70_unload_stop: shifts %0d rd_valid %b rd_data %h want 63 1 89abcdef",
                              sh70 - s0, b70.rd_valid, b70.rd_data);
        end
        s1 = sh70;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (sh70 != s1 || ce70 !== 1'b0) begin
            n_bad++; $display("FAIL stall70_unload_hold: extra shifts %0d ce %b want 0 0", sh70 - s1, ce70);
        end
        b70.rd_ready = 1'b1;
        k = 0;
        while (!done70 && k < 200) begin @(negedge CLK); k++; end
        n_cmp++;
        if (rc70 - r0 != 3 || rw70[r0 % 64] !== 32'h89AB_CDEF || rw70[(r0 + 1) % 64] !== 32'h0123_4567
            || rw70[(r0 + 2) % 64] !== 32'h0000_0015) begin
            n_bad++; $display("FAIL stall70_unload_words: n=%0d %h %h %h want 3 89abcdef 01234567 00000015",
                              rc70 - r0, rw70[r0 % 64], rw70[(r0 + 1) % 64], rw70[(r0 + 2) % 64]);
        end
        n_cmp++;
        if (q70 !== 70'h0 || busy70 !== 1'b0) begin
            n_bad++; $display("FAIL stall70_unload_end: chain %h busy %b want 0 0", q70, busy70);
        end
    endtask

    task automatic test_mid_reset();
        int k, s0, r0;
        preset26(26'h0);
        b26.wr_data = 32'h0333_CCCC; b26.wr_valid = 1'b1;
        s0 = sh26;
        issue26(2'd0);
        k = 1;
        while (sh26 - s0 < 10 && k < 100) begin @(negedge CLK); k++; end
        RSTB = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({busy26, se26, ce26, si26, b26.wr_ready, done26} !== 6'b0) begin
            n_bad++; $display("FAIL midreset_outputs: busy/se/ce/si/wr_ready/done got %b want 000000",
                              {busy26, se26, ce26, si26, b26.wr_ready, done26});
        end
        RSTB = 1'b1; b26.wr_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (b26.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL midreset_cmd_ready: got %b want 1", b26.cmd_ready);
        end
        dd26 = 26'h0AB_CDEF; b26.rd_ready = 1'b1; r0 = rc26;
        issue26(2'd1);
        k = 1;
        while (!done26 && k < 200) begin @(negedge CLK); k++; end
        n_cmp++;
        if (k != 29 || rc26 - r0 != 1 || rw26[r0 % 64] !== 32'h00AB_CDEF) begin
            n_bad++; $display("FAIL midreset_unload: done@%0d words %0d data %h want 29 1 00abcdef",
                              k, rc26 - r0, rw26[r0 % 64]);
        end
    endtask

    task automatic test_back_to_back();
        int k, r0;
        preset26(26'h0);
        hold26 = 1'b1; b26.rd_ready = 1'b1;
        b26.wr_data = 32'h01C3_9E5A; b26.wr_valid = 1'b1;
        issue26(2'd0);
        k = 1;
        while (!done26 && k < 200) begin @(negedge CLK); k++; end
        n_cmp++;
        if (done26 !== 1'b1 || b26.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_done_ready: done %b cmd_ready %b want 1 1", done26, b26.cmd_ready);
        end
        b26.wr_valid = 1'b0; b26.cmd_op = 2'd2; b26.cmd_valid = 1'b1; r0 = rc26;
        @(negedge CLK);
        b26.cmd_valid = 1'b0;
        n_cmp++;
        if (busy26 !== 1'b1 || se26 !== 1'b0 || ce26 !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept: busy/se/ce got %b%b%b want 101", busy26, se26, ce26);
        end
        k = 1;
        while (!done26 && k < 200) begin @(negedge CLK); k++; end
        n_cmp++;
        if (rc26 - r0 != 1 || rw26[r0 % 64] !== 32'h01C3_9E5A) begin
            n_bad++; $display("FAIL b2b_word: words %0d data %h want 1 01c39e5a", rc26 - r0, rw26[r0 % 64]);
        end
        n_cmp++;
        if (q26 !== 26'h1C3_9E5A) begin n_bad++; $display("FAIL b2b_chain: got %h want 1c39e5a", q26); end
        hold26 = 1'b0;
    endtask

    initial begin
        b26.cmd_valid = 1'b0; b26.cmd_op = 2'd0; b26.wr_data = '0; b26.wr_valid = 1'b0; b26.rd_ready = 1'b0;
        b70.cmd_valid = 1'b0; b70.cmd_op = 2'd0; b70.wr_data = '0; b70.wr_valid = 1'b0; b70.rd_ready = 1'b0;
        test_reset();
        test_load26();
        test_unload26();
        test_recirc70();
        test_load_stall70();
        test_unload_stall70();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
